// File: rtl/note_pkg.sv
// Shared definitions for the keyboard note selector.
// Provides key count, debounce depth, the "no note" id, the frequency-id type
// and the scan FSM state encoding.
package note_pkg;

  localparam int unsigned NUM_KEYS        = 25;
  localparam int unsigned DEBOUNCE_FRAMES = 3;

  typedef logic [4:0] freq_id_t;

  localparam freq_id_t NONE_ID = 5'h1F;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCmp
  } scan_state_e;

endpackage

// File: rtl/key_debounce.sv
// Per-key frame-rate debouncer.
// Ports:
//   clock  - pixel clock
//   reset  - synchronous, active-high
//   tick   - one-clock frame pulse; state only advances on it
//   sample - synchronised raw key level
//   stable - debounced key level
// A change is accepted after DebounceFrames consecutive differing samples.
module key_debounce
  import note_pkg::*;
#(
  parameter int unsigned DebounceFrames = DEBOUNCE_FRAMES
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic sample,
  output logic stable
);

  localparam logic [1:0] Target = 2'(DebounceFrames);

  logic [1:0] count_q;
  logic       stable_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= 2'd0;
      stable_q <= 1'b0;
    end else if (tick) begin
      if (sample == stable_q) begin
        count_q <= 2'd0;
      end else if (count_q + 2'd1 == Target) begin
        stable_q <= sample;
        count_q  <= 2'd0;
      end else begin
        count_q <= count_q + 2'd1;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/note_select.sv
// Converts raw keyboard note lines into the lowest / second-lowest pressed
// note ids plus a one-frame new-frequency strobe.
// Ports:
//   clock     - pixel clock
//   reset     - synchronous, active-high
//   vsync     - active-low frame sync (async); its falling edge is the frame tick
//   keys      - raw key levels, 1 = pressed (async)
//   freq_id1  - lowest debounced pressed key id, else NONE_ID
//   freq_id2  - second-lowest debounced pressed key id, else NONE_ID
//   new_f_out - high for one full frame when the id pair changes
//   num_notes - min(pressed count, 2), updated together with the ids
module note_select
  import note_pkg::*;
#(
  parameter int unsigned NumKeys        = NUM_KEYS,
  parameter int unsigned DebounceFrames = DEBOUNCE_FRAMES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vsync,
  input  logic [NumKeys-1:0] keys,
  output freq_id_t           freq_id1,
  output freq_id_t           freq_id2,
  output logic               new_f_out,
  output logic [1:0]         num_notes
);

  localparam int unsigned     IdxW    = $clog2(NumKeys);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumKeys - 1);

  // Synchronisers and tick detector
  logic               vsync_s1_q, vsync_s2_q, vsync_s3_q;
  logic               tick_q;
  logic [NumKeys-1:0] keys_s1_q, keys_s2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      // vsync idles high; resetting to 1 avoids a spurious tick
      vsync_s1_q <= 1'b1;
      vsync_s2_q <= 1'b1;
      vsync_s3_q <= 1'b1;
      tick_q     <= 1'b0;
      keys_s1_q  <= '0;
      keys_s2_q  <= '0;
    end else begin
      vsync_s1_q <= vsync;
      vsync_s2_q <= vsync_s1_q;
      vsync_s3_q <= vsync_s2_q;
      tick_q     <= vsync_s3_q & ~vsync_s2_q;
      keys_s1_q  <= keys;
      keys_s2_q  <= keys_s1_q;
    end
  end

  // Debounce
  logic [NumKeys-1:0] stable;

  for (genvar i = 0; i < NumKeys; i++) begin : g_key
    key_debounce #(
      .DebounceFrames(DebounceFrames)
    ) u_key_debounce (
      .clock (clock),
      .reset (reset),
      .tick  (tick_q),
      .sample(keys_s2_q[i]),
      .stable(stable[i])
    );
  end

  // Scan FSM and strobe logic
  scan_state_e     state_q;
  logic [IdxW-1:0] idx_q;
  freq_id_t        cand1_q, cand2_q;
  logic [1:0]      cnt_q;
  freq_id_t        pend1_q, pend2_q;
  logic [1:0]      pend_n_q;
  logic            pending_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cand1_q   <= NONE_ID;
      cand2_q   <= NONE_ID;
      cnt_q     <= 2'd0;
      pend1_q   <= NONE_ID;
      pend2_q   <= NONE_ID;
      pend_n_q  <= 2'd0;
      pending_q <= 1'b0;
      freq_id1  <= NONE_ID;
      freq_id2  <= NONE_ID;
      num_notes <= 2'd0;
      new_f_out <= 1'b0;
    end else if (tick_q) begin
      // A tick always (re)starts the scan; the debouncers update on this
      // same edge so the scan sees this frame's stable values.
      state_q <= StScan;
      idx_q   <= '0;
      cand1_q <= NONE_ID;
      cand2_q <= NONE_ID;
      cnt_q   <= 2'd0;
      // Dropping the strobe first guarantees a low frame between strobes.
      if (new_f_out) begin
        new_f_out <= 1'b0;
      end else if (pending_q) begin
        freq_id1  <= pend1_q;
        freq_id2  <= pend2_q;
        num_notes <= pend_n_q;
        new_f_out <= 1'b1;
        pending_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StIdle;
        end
        StScan: begin
          if (stable[idx_q]) begin
            if (cnt_q == 2'd0) begin
              cand1_q <= freq_id_t'(idx_q);
            end else if (cnt_q == 2'd1) begin
              cand2_q <= freq_id_t'(idx_q);
            end
            if (cnt_q != 2'd2) begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
          if (idx_q == LastIdx) begin
            state_q <= StCmp;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StCmp: begin
          if ({cand1_q, cand2_q} != {freq_id1, freq_id2}) begin
            pend1_q   <= cand1_q;
            pend2_q   <= cand2_q;
            pend_n_q  <= cnt_q;
            pending_q <= 1'b1;
          end else begin
            // Change reverted before it was presented
            pending_q <= 1'b0;
          end
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_select.sv
module tb_note_select;
  import note_pkg::*;

  logic                clock;
  logic                reset;
  logic                vsync;
  logic [NUM_KEYS-1:0] keys;
  freq_id_t            freq_id1;
  freq_id_t            freq_id2;
  logic                new_f_out;
  logic [1:0]          num_notes;

  int n_checks = 0;
  int n_fail   = 0;

  note_select dut (
    .clock    (clock),
    .reset    (reset),
    .vsync    (vsync),
    .keys     (keys),
    .freq_id1 (freq_id1),
    .freq_id2 (freq_id2),
    .new_f_out(new_f_out),
    .num_notes(num_notes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NUM_KEYS-1:0] k;
    logic [4:0]          id1;
    logic [4:0]          id2;
    logic [1:0]          n;
    logic                nf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [NUM_KEYS-1:0] key(input int i);
    logic [NUM_KEYS-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic void add(input logic [NUM_KEYS-1:0] k, input logic [4:0] id1,
                              input logic [4:0] id2, input logic [1:0] n, input logic nf);
    vec_t v;
    v.k   = k;
    v.id1 = id1;
    v.id2 = id2;
    v.n   = n;
    v.nf  = nf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] id1, input logic [4:0] id2,
                               input logic [1:0] n, input logic nf);
    check({tag, ".freq_id1"}, int'(freq_id1), int'(id1));
    check({tag, ".freq_id2"}, int'(freq_id2), int'(id2));
    check({tag, ".num_notes"}, int'(num_notes), int'(n));
    check({tag, ".new_f_out"}, int'(new_f_out), int'(nf));
    // Ordering invariants
    check({tag, ".order"},
          int'((freq_id2 == NONE_ID) || (freq_id1 < freq_id2)), 1);
    check({tag, ".none_implies_none"},
          int'((freq_id1 != NONE_ID) || (freq_id2 == NONE_ID)), 1);
  endtask

  // One frame: keys settle, vsync pulses low, then enough clocks for the
  // tick and the full scan to finish before sampling.
  task automatic run_frame(input logic [NUM_KEYS-1:0] k);
    keys = k;
    repeat (4) @(negedge clock);
    vsync = 1'b0;
    repeat (4) @(negedge clock);
    vsync = 1'b1;
    repeat (40) @(negedge clock);
  endtask

  initial begin
    logic [NUM_KEYS-1:0] none;
    logic [NUM_KEYS-1:0] k123;
    logic [NUM_KEYS-1:0] k29;
    none  = '0;
    k123  = key(12) | key(3) | key(20);
    k29   = key(2) | key(9);

    reset = 1'b1;
    vsync = 1'b1;
    keys  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_outputs("reset", 5'd31, 5'd31, 2'd0, 1'b0);

    // 1: idle frames
    for (int i = 0; i < 4; i++) add(none, 31, 31, 0, 0);
    // 2: key 7 steady, accepted on 3rd tick, strobed on 4th
    add(key(7), 31, 31, 0, 0);
    add(key(7), 31, 31, 0, 0);
    add(key(7), 31, 31, 0, 0);
    add(key(7), 7, 31, 1, 1);
    add(key(7), 7, 31, 1, 0);
    add(key(7), 7, 31, 1, 0);
    // 3: keys 12, 3, 20; 7 released
    add(k123, 7, 31, 1, 0);
    add(k123, 7, 31, 1, 0);
    add(k123, 7, 31, 1, 0);
    add(k123, 3, 12, 2, 1);
    add(k123, 3, 12, 2, 0);
    // release all
    add(none, 3, 12, 2, 0);
    add(none, 3, 12, 2, 0);
    add(none, 3, 12, 2, 0);
    add(none, 31, 31, 0, 1);
    add(none, 31, 31, 0, 0);
    // 4: key 5 toggling never debounces
    for (int i = 0; i < 8; i++) add((i % 2 == 0) ? key(5) : none, 31, 31, 0, 0);
    // 5: key 2 then 9; 9 released while the strobe for 2/31 is high
    add(key(2), 31, 31, 0, 0);
    add(k29, 31, 31, 0, 0);
    add(k29, 31, 31, 0, 0);
    add(k29, 2, 31, 1, 1);
    add(key(2), 2, 31, 1, 0);
    add(key(2), 2, 9, 2, 1);
    add(key(2), 2, 9, 2, 0);
    add(key(2), 2, 31, 1, 1);
    add(key(2), 2, 31, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i].k);
      check_outputs($sformatf("frame%0d", i), vecs[i].id1, vecs[i].id2, vecs[i].n, vecs[i].nf);
    end

    // 6: reset in the middle of a scan with key 4 held
    keys = key(4);
    repeat (4) @(negedge clock);
    vsync = 1'b0;
    repeat (8) @(negedge clock);
    check("midscan.state_scan", int'(dut.state_q == StScan), 1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    vsync = 1'b1;
    @(negedge clock);
    check_outputs("after_reset", 5'd31, 5'd31, 2'd0, 1'b0);
    check("after_reset.state_idle", int'(dut.state_q == StIdle), 1);
    for (int i = 0; i < 3; i++) begin
      run_frame(key(4));
      check_outputs($sformatf("rekey%0d", i), 5'd31, 5'd31, 2'd0, 1'b0);
    end
    run_frame(key(4));
    check_outputs("rekey3", 5'd4, 5'd31, 2'd1, 1'b1);
    run_frame(key(4));
    check_outputs("rekey4", 5'd4, 5'd31, 2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
